fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Program-counter / fetch stage sitting directly upstream of the control decoder.
//   Drives the instruction ROM address, consumes the decoder's branch fields
//   (ConditionalJump, BranchAbsOrRel, PCTarg, BranchConditions, Ack), holds the
//   compare-flag register and sequences start/run/halt of the program.
// PARAMETERS
//   PC_W       10      program counter / ROM address width
//   START_ADDR 10'd0   PC value loaded on reset and on Start
//   LUT0       10'd0   branch target table entry 0 (abs addr, or signed rel offset)
//   LUT1       10'd0   branch target table entry 1
//   LUT2       10'd0   branch target table entry 2
//   LUT3       10'd0   branch target table entry 3
// PORTS
//   Clk              in   1     system clock, rising edge
//   Reset            in   1     asynchronous, active-high reset
//   Start            in   1     level; restart program from START_ADDR
//   ConditionalJump  in   1     decoder: current instruction is a branch
//   BranchAbsOrRel   in   1     decoder: 0 = absolute, 1 = PC-relative
//   BranchConditions in   2     decoder: condition select
//   PCTarg           in   2     decoder: branch target table index
//   Ack              in   1     decoder: halt instruction (9'h1FF)
//   FlagWrEn         in   1     CMP executed this cycle; latch ZeroIn/NegIn
//   ZeroIn           in   1     ALU zero result of CMP
//   NegIn            in   1     ALU negative result of CMP
//   ProgCtr          out  PC_W  instruction ROM address (registered)
//   Running          out  1     registered; 1 while state == RUN
//   Done             out  1     registered; 1 while state == HALT
// BEHAVIOUR
//   Reset (async, immediate): ProgCtr=START_ADDR, state=IDLE, ZeroF=NegF=0,
//     Running=0, Done=0.
//   States: IDLE, RUN, HALT. Outputs all registered; no comb path in->out.
//   Start=1 in any state (sampled at edge): next ProgCtr=START_ADDR, flags
//     cleared, state=RUN. Start has priority over Ack, branch and increment.
//   IDLE: ProgCtr held at START_ADDR; waits for Start.
//   RUN, per edge, priority order:
//     1. Ack=1 -> state=HALT, ProgCtr held (stays on halt instruction).
//        Ack beats ConditionalJump (halt encoding also decodes as branch).
//     2. ConditionalJump=1 and cond true -> ProgCtr = target.
//     3. otherwise ProgCtr = ProgCtr + 1, wraps 2^PC_W-1 -> 0.
//   Decoder inputs are sampled with respect to the current ProgCtr; each
//     instruction occupies exactly one cycle (no stall, no delay slot).
//   cond (BranchConditions): 00 always; 01 EQ = ZeroF; 10 LT = NegF;
//     11 GT = !ZeroF & !NegF.
//   target: idx = PCTarg; abs: LUT[idx]; rel: ProgCtr + LUT[idx] taken as
//     PC_W-bit two's complement, result modulo 2^PC_W (wraps both ways).
//   Flags: ZeroF/NegF load ZeroIn/NegIn on an edge with FlagWrEn=1 in RUN;
//     a branch in the same cycle as FlagWrEn uses the OLD flags. FlagWrEn
//     ignored in IDLE/HALT.
//   HALT: ProgCtr, flags frozen; Done=1; leaves only via Start or Reset.
//   Reset asserted mid-RUN/HALT: immediate return to reset values, no
//     partial update.
// TESTING
//   Reset, no Start, 10 cycles -> ProgCtr=0, Running=0, Done=0 throughout.
//   Start pulse, no branches -> ProgCtr 0,1,2,...; at 1023 next value 0.
//   LUT1=10'd200, PC=5, CJ=1, Abs, Cond=00, PCTarg=1 -> ProgCtr=200 next cycle.
//   LUT2=10'h3FC (-4), PC=2, Rel, always -> ProgCtr=1022 (wrap);
//     PC=20 -> 16.
//   CMP FlagWrEn=1 Zero=1 with EQ branch same cycle (old Z=0) -> not taken
//     (PC+1); EQ branch next cycle -> taken.
//   Ack=1 with CJ=1 at PC=37 -> Done=1, ProgCtr stays 37 for 5 cycles;
//     Start -> ProgCtr=0, Running=1, Done=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, branch resolution, compare flags and run/halt sequencing
module fetch_pc_unit #(
  parameter int PC_W = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [PC_W-1:0] LUT0 = '0,
  parameter logic [PC_W-1:0] LUT1 = '0,
  parameter logic [PC_W-1:0] LUT2 = '0,
  parameter logic [PC_W-1:0] LUT3 = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            ConditionalJump,
  input  logic            BranchAbsOrRel,
  input  logic [1:0]      BranchConditions,
  input  logic [1:0]      PCTarg,
  input  logic            Ack,
  input  logic            FlagWrEn,
  input  logic            ZeroIn,
  input  logic            NegIn,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic zero_f, neg_f, cond, take;
  logic [PC_W-1:0] lut_val, target;
  always_comb begin
    lut_val = PCTarg == 2'd0 ? LUT0 : PCTarg == 2'd1 ? LUT1 : PCTarg == 2'd2 ? LUT2 : LUT3;
    target  = BranchAbsOrRel ? ProgCtr + lut_val : lut_val;
    cond    = BranchConditions == 2'd0 ? 1'b1 : BranchConditions == 2'd1 ? zero_f :
              BranchConditions == 2'd2 ? neg_f : !zero_f && !neg_f;
    take    = ConditionalJump && cond;
  end
  // Branch resolution reads the flags before this edge's CMP update lands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= START_ADDR;
      zero_f  <= 1'b0;
      neg_f   <= 1'b0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else if (Start) begin
      state   <= RUN;
      ProgCtr <= START_ADDR;
      zero_f  <= 1'b0;
      neg_f   <= 1'b0;
      Running <= 1'b1;
      Done    <= 1'b0;
    end else if (state == RUN) begin
      if (FlagWrEn) begin
        zero_f <= ZeroIn;
        neg_f  <= NegIn;
      end
      if (Ack) begin
        state   <= HALT;
        Running <= 1'b0;
        Done    <= 1'b1;
      end else begin
        ProgCtr <= take ? target : ProgCtr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 0, cj = 0, rel = 0, ack = 0, fw = 0, zin = 0, nin = 0;
  logic [1:0] bc = 0, tg = 0;
  logic [9:0] pc;
  logic running, done;
  int checks = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  fetch_pc_unit #(
    .PC_W(10), .START_ADDR(10'd0),
    .LUT0(10'd50), .LUT1(10'd200), .LUT2(10'h3FC), .LUT3(10'd300)
  ) dut (
    .Clk(clk), .Reset(rst), .Start(start), .ConditionalJump(cj),
    .BranchAbsOrRel(rel), .BranchConditions(bc), .PCTarg(tg), .Ack(ack),
    .FlagWrEn(fw), .ZeroIn(zin), .NegIn(nin),
    .ProgCtr(pc), .Running(running), .Done(done)
  );

  always #5 clk = ~clk;

  always begin
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pc, running, done} !== e) begin
        fails++;
        $display("FAIL cycle_check: got pc=%0d run=%b done=%b expected pc=%0d run=%b done=%b",
                 pc, running, done, e[11:2], e[1], e[0]);
      end
    end
  end

  task automatic step(input logic s, input logic j, input logic r, input logic [1:0] b,
                      input logic [1:0] t, input logic a, input logic f, input logic z,
                      input logic n, input int p, input logic ru, input logic dn);
    @(negedge clk);
    start = s; cj = j; rel = r; bc = b; tg = t; ack = a; fw = f; zin = z; nin = n;
    exp_q.push_back({p[9:0], ru, dn});
  endtask

  task automatic inc(input int first, input int last);
    for (int p = first; p <= last; p++) step(0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, p % 1024, 1, 0);
  endtask

  task automatic direct(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    inc(1, 1024);
    inc(1, 5);
    step(0, 1, 0, 2'd0, 2'd1, 0, 0, 0, 0, 200, 1, 0);
    inc(201, 201);
    @(negedge clk);
    start = 0; cj = 0; ack = 0; fw = 0;
    wait (exp_q.size() == 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    direct("async_reset", {pc, running, done}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    inc(1, 2);
    step(0, 1, 1, 2'd0, 2'd2, 0, 0, 0, 0, 1022, 1, 0);
    inc(1023, 1044);
    step(0, 1, 1, 2'd0, 2'd2, 0, 0, 0, 0, 16, 1, 0);
    step(0, 1, 0, 2'd1, 2'd1, 0, 1, 1, 0, 17, 1, 0);
    step(0, 1, 0, 2'd1, 2'd1, 0, 0, 0, 0, 200, 1, 0);
    step(1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 2'd1, 2'd1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 1, 2, 1, 0);
    step(0, 1, 0, 2'd2, 2'd0, 0, 0, 0, 0, 50, 1, 0);
    step(0, 1, 0, 2'd3, 2'd3, 0, 0, 0, 0, 51, 1, 0);
    step(0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0, 52, 1, 0);
    step(0, 1, 0, 2'd3, 2'd3, 0, 0, 0, 0, 300, 1, 0);
    step(1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    inc(1, 37);
    step(0, 1, 0, 2'd0, 2'd1, 1, 0, 0, 0, 37, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'd0, 2'd1, 0, 1, 1, 0, 37, 0, 1);
    step(1, 1, 0, 2'd0, 2'd1, 1, 0, 0, 0, 0, 1, 0);
    inc(1, 1);
    @(negedge clk);
    start = 0; cj = 0; ack = 0; fw = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
